pix2vidstream: RTL and testbench

- Packs a 24-bit pixel AXI stream into bus-width memory words, in the format the frame-buffer writer stores and `vidstream2pix` unpacks.
- Colour reduction, packing order and byte order are the exact inverse of that decoder.
- Sits between the pixel source (camera or overlay) and the video DMA writer.

---
 rtl/pix2vidstream.sv | 132 +++++++++++++
 tb/tb_pix2vidstream.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pix2vidstream.sv
// Pixel-to-memory-word packer: colour-reduces 24-bit pixels to a mode-dependent
// code, packs codes into BUS_DATA_WIDTH words and flushes early on end of line.
module pix2vidstream #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter bit OPT_MSB_FIRST  = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  input  logic [23:0]               S_AXIS_TDATA,
  input  logic                      S_AXIS_TLAST,
  input  logic                      S_AXIS_TUSER,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [BUS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST,
  output logic                      M_AXIS_TUSER,
  input  logic [2:0]                i_mode
);

  localparam int BW = BUS_DATA_WIDTH;
  localparam int CW = $clog2(BW) + 1;
  localparam int NB = BW / 8;

  typedef struct packed {
    logic [31:0] code;
    logic [2:0]  lb;    // log2 of code width
    logic        last;
    logic        user;
  } conv_t;

  function automatic logic [31:0] to_code(input logic [2:0] m, input logic [23:0] p);
    case (m)
      3'd0:    to_code = {31'd0, p[15]};
      3'd1:    to_code = {30'd0, p[15:14]};
      3'd2:    to_code = {28'd0, p[15:12]};
      3'd3:    to_code = {28'd0, p[3:0]};
      3'd4:    to_code = {24'd0, p[7:0]};
      3'd5:    to_code = {24'd0, p[23:21], p[15:13], p[7:6]};
      3'd6:    to_code = {16'd0, p[23:19], p[15:10], p[7:3]};
      default: to_code = {8'd0, p};
    endcase
  endfunction

  function automatic logic [2:0] log2_bits(input logic [2:0] m);
    case (m)
      3'd0:       log2_bits = 3'd0;
      3'd1:       log2_bits = 3'd1;
      3'd2, 3'd3: log2_bits = 3'd2;
      3'd4, 3'd5: log2_bits = 3'd3;
      3'd6:       log2_bits = 3'd4;
      default:    log2_bits = 3'd5;
    endcase
  endfunction

  logic [1:0]    vld_pipe;  // [0] conversion stage, [1] output register
  conv_t         conv_q;
  logic          line_start;
  logic [2:0]    line_mode, eff_mode;
  logic [BW-1:0] w_q, w_next, w_rev, w_out, code_ext;
  logic [CW-1:0] cnt, ppw_m1, shamt;
  logic          u_q, completes, pack_acc, conv_adv;

  // Mode is only sampled on the first pixel of a line and held until TLAST.
  assign eff_mode = line_start ? i_mode : line_mode;

  always_comb begin
    ppw_m1   = CW'(BW >> conv_q.lb) - CW'(1);
    shamt    = OPT_MSB_FIRST ? (CW'(BW) - ((cnt + CW'(1)) << conv_q.lb))
                             : (cnt << conv_q.lb);
    code_ext = BW'(conv_q.code);
    w_next   = w_q | (code_ext << shamt);
  end

  assign completes = vld_pipe[0] && ((cnt == ppw_m1) || conv_q.last);
  assign pack_acc  = vld_pipe[0] && (!completes || !vld_pipe[1] || M_AXIS_TREADY);
  assign conv_adv  = !vld_pipe[0] || pack_acc;

  assign S_AXIS_TREADY = conv_adv;
  assign M_AXIS_TVALID = vld_pipe[1];

  for (genvar i = 0; i < NB; i++) begin : g_brev
    assign w_rev[i*8 +: 8] = w_next[BW-8-i*8 +: 8];
  end
  assign w_out = OPT_MSB_FIRST ? w_rev : w_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_pipe     <= '0;
      conv_q       <= '0;
      line_start   <= 1'b1;
      line_mode    <= '0;
      w_q          <= '0;
      cnt          <= '0;
      u_q          <= 1'b0;
      M_AXIS_TDATA <= '0;
      M_AXIS_TLAST <= 1'b0;
      M_AXIS_TUSER <= 1'b0;
    end else begin
      if (conv_adv) begin
        vld_pipe[0] <= S_AXIS_TVALID;
        if (S_AXIS_TVALID) begin
          conv_q.code <= to_code(eff_mode, S_AXIS_TDATA);
          conv_q.lb   <= log2_bits(eff_mode);
          conv_q.last <= S_AXIS_TLAST;
          conv_q.user <= S_AXIS_TUSER;
          line_mode   <= eff_mode;
          line_start  <= S_AXIS_TLAST;
        end
      end
      if (vld_pipe[1] && M_AXIS_TREADY)
        vld_pipe[1] <= 1'b0;
      if (pack_acc) begin
        if (completes) begin
          vld_pipe[1]  <= 1'b1;
          M_AXIS_TDATA <= w_out;
          M_AXIS_TLAST <= conv_q.last;
          M_AXIS_TUSER <= u_q | conv_q.user;
          w_q          <= '0;
          cnt          <= '0;
          u_q          <= 1'b0;
        end else begin
          w_q <= w_next;
          cnt <= cnt + CW'(1);
          u_q <= u_q | conv_q.user;
        end
      end
    end
  end

endmodule

// File: tb/tb_pix2vidstream.sv
// Bench for pix2vidstream: two instances (MSB-first and LSB-first) share one
// pixel stream; words are checked against a line/word-level packing model.
module tb_pix2vidstream;
  localparam int BUS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_last = 1'b0, s_user = 1'b0;
  logic [23:0] s_data = '0;
  logic [2:0]  mode = '0;
  logic        m_ready = 1'b1;
  logic        s_ready1, s_ready0, v1, v0, l1, l0, u1, u0;
  logic [31:0] d1, d0;

  always #5 clk = ~clk;

  pix2vidstream #(.BUS_DATA_WIDTH(BUS), .OPT_MSB_FIRST(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready1), .S_AXIS_TDATA(s_data),
    .S_AXIS_TLAST(s_last), .S_AXIS_TUSER(s_user),
    .M_AXIS_TVALID(v1), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(d1),
    .M_AXIS_TLAST(l1), .M_AXIS_TUSER(u1), .i_mode(mode));

  pix2vidstream #(.BUS_DATA_WIDTH(BUS), .OPT_MSB_FIRST(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready0), .S_AXIS_TDATA(s_data),
    .S_AXIS_TLAST(s_last), .S_AXIS_TUSER(s_user),
    .M_AXIS_TVALID(v0), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(d0),
    .M_AXIS_TLAST(l0), .M_AXIS_TUSER(u0), .i_mode(mode));

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d0;
    logic        last;
    logic        user;
  } word_t;

  word_t expq[$];
  word_t gotq[$];
  word_t mon_w;
  int    n_checks = 0;
  int    n_fail = 0;
  int    rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled

  // Reference model state
  bit          line_start = 1'b1;
  logic [2:0]  line_mode = '0;
  logic [31:0] codes[$];
  bit          cur_u = 1'b0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom % 2);
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && v1 === 1'b1 && m_ready === 1'b1) begin
      mon_w.d1 = d1; mon_w.d0 = d0; mon_w.last = l1; mon_w.user = u1;
      gotq.push_back(mon_w);
    end
  end

  function automatic int bits_of(input logic [2:0] m);
    case (m)
      3'd0: return 1;
      3'd1: return 2;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] code_of(input logic [2:0] m, input logic [23:0] p);
    logic [7:0] r, g, b;
    r = p[23:16]; g = p[15:8]; b = p[7:0];
    case (m)
      3'd0: return {31'd0, g[7]};
      3'd1: return {30'd0, g[7:6]};
      3'd2: return {28'd0, g[7:4]};
      3'd3: return {28'd0, b[3:0]};
      3'd4: return {24'd0, b};
      3'd5: return {24'd0, r[7:5], g[7:5], b[7:6]};
      3'd6: return {16'd0, r[7:3], g[7:2], b[7:3]};
      default: return {8'h00, r, g, b};
    endcase
  endfunction

  task automatic model_reset();
    line_start = 1'b1;
    codes.delete();
    cur_u = 1'b0;
  endtask

  task automatic model_push(input logic [23:0] p, input logic l, input logic u);
    int b;
    logic [31:0] wm, wl, rv;
    word_t w;
    if (line_start) line_mode = mode;
    b = bits_of(line_mode);
    codes.push_back(code_of(line_mode, p));
    cur_u = cur_u | u;
    if (codes.size() == BUS / b || l) begin
      wm = '0; wl = '0;
      for (int k = 0; k < codes.size(); k++) begin
        wm = wm | (codes[k] << (BUS - (k + 1) * b));
        wl = wl | (codes[k] << (k * b));
      end
      for (int i = 0; i < 4; i++) rv[8*i +: 8] = wm[8*(3-i) +: 8];
      w.d1 = rv; w.d0 = wl; w.last = l; w.user = cur_u;
      expq.push_back(w);
      codes.delete();
      cur_u = 1'b0;
    end
    line_start = l;
  endtask

  // Called and returns at posedge+1; the handshake is on the posedge in between.
  task automatic send_px(input logic [23:0] p, input logic l, input logic u);
    int t;
    bit ok;
    s_valid = 1'b1; s_data = p; s_last = l; s_user = u;
    t = 0; ok = 1'b0;
    while (!ok && t < 1000) begin
      @(negedge clk);
      if (s_ready1 === 1'b1) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        t++;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: S_AXIS_TREADY stuck at %b, required 1", s_ready1);
      s_valid = 1'b0;
    end else begin
      model_push(p, l, u);
      @(posedge clk); #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((gotq.size() < expq.size() || v1 === 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (t >= 2000) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words, required %0d", gotq.size(), expq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({v1, l1, u1, d1, v0, l0, u0, d0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b u=%b d1=%h d0=%h, required all 0", v1, l1, u1, d1, d0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_ready1 !== 1'b1 || s_ready0 !== 1'b1 || v1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got tready=%b/%b tvalid=%b, required 1/1/0", s_ready1, s_ready0, v1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bw();
    mode = 3'd0;
    for (int i = 0; i < 32; i++)
      if (i == 0) send_px({8'($urandom), 8'h80, 8'($urandom)}, 1'b0, 1'b0);
      else send_px({8'($urandom), 8'($urandom) & 8'h7f, 8'($urandom)}, 1'(i == 31), 1'b0);
    drain();
    n_checks++;
    if (gotq.size() !== 1 || gotq[0].d1 !== 32'h00000080 || gotq[0].d0 !== 32'h00000001
        || gotq[0].last !== 1'b1) begin
      n_fail++;
      $display("FAIL bw_word: got n=%0d word %h, required 1 word d1=00000080 d0=00000001 last=1",
               gotq.size(), gotq.size() > 0 ? gotq[0] : '0);
    end
    n_checks++;
    if (gotq.size() !== expq.size()) begin
      n_fail++;
      $display("FAIL bw_count: got %0d words, required %0d", gotq.size(), expq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      n_checks++;
      if (gotq[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL bw_model[%0d]: got %h, required %h", i, gotq[i], expq[i]);
      end
    end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_clr16();
    mode = 3'd6;
    send_px(24'hFF0000, 1'b0, 1'b1);
    send_px(24'h0000FF, 1'b0, 1'b0);
    drain();
    n_checks++;
    if (gotq.size() !== 1 || gotq[0].d1 !== 32'h1F0000F8 || gotq[0].d0 !== 32'h001FF800
        || gotq[0].user !== 1'b1 || gotq[0].last !== 1'b0) begin
      n_fail++;
      $display("FAIL clr16_word: got n=%0d word %h, required d1=1F0000F8 d0=001FF800 last=0 user=1",
               gotq.size(), gotq.size() > 0 ? gotq[0] : '0);
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      n_checks++;
      if (gotq[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL clr16_model[%0d]: got %h, required %h", i, gotq[i], expq[i]);
      end
    end
    gotq.delete(); expq.delete();
    // close the open line so the next test starts a new one
    send_px(24'h123456, 1'b1, 1'b0);
    drain();
    gotq.delete(); expq.delete();
  endtask

  task automatic test_gray4_flush();
    bit seen;
    mode = 3'd2;
    send_px({8'($urandom), 8'hA0, 8'($urandom)}, 1'b0, 1'b0);
    send_px({8'($urandom), 8'h50, 8'($urandom)}, 1'b0, 1'b0);
    send_px({8'($urandom), 8'hF0, 8'($urandom)}, 1'b1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (v1 === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL gray4_latency: got tvalid=%b two cycles after handshake, required 1", v1);
    end
    @(posedge clk); #1;
    drain();
    n_checks++;
    if (gotq.size() !== 1 || gotq[0].d1 !== 32'h0000F0A5 || gotq[0].last !== 1'b1) begin
      n_fail++;
      $display("FAIL gray4_word: got n=%0d word %h, required d1=0000F0A5 last=1",
               gotq.size(), gotq.size() > 0 ? gotq[0] : '0);
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      n_checks++;
      if (gotq[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL gray4_model[%0d]: got %h, required %h", i, gotq[i], expq[i]);
      end
    end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_backpressure();
    logic [65:0] snap;
    mode = 3'd7;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send_px(24'($urandom), 1'(i == 11), 1'($urandom % 2));
      end
      begin
        int t;
        t = 0;
        while (v1 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        rdy_mode = 2;
        @(negedge clk); @(negedge clk);
        snap = {d1, d0, l1, u1};
        n_checks++;
        if (v1 !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_stall_valid: got tvalid=%b, required 1", v1);
        end
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if ({d1, d0, l1, u1} !== snap || v1 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got %h v=%b, required %h v=1", {d1, d0, l1, u1}, v1, snap);
          end
        end
        n_checks++;
        if (s_ready1 !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_tready: got %b while stalled, required 0", s_ready1);
        end
        rdy_mode = 0;
      end
    join
    drain();
    n_checks++;
    if (gotq.size() !== 12 || expq.size() !== 12) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words, required 12 (model %0d)", gotq.size(), expq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      n_checks++;
      if (gotq[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL bp_model[%0d]: got %h, required %h", i, gotq[i], expq[i]);
      end
    end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_midline_mode();
    mode = 3'd2;
    for (int i = 0; i < 10; i++) begin
      send_px(24'($urandom), 1'(i == 9), 1'(i == 0));
      if (i == 1) mode = 3'd6;
    end
    for (int i = 0; i < 4; i++) send_px(24'($urandom), 1'(i == 3), 1'b0);
    drain();
    n_checks++;
    if (gotq.size() !== 4) begin
      n_fail++;
      $display("FAIL midline_count: got %0d words, required 4", gotq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      n_checks++;
      if (gotq[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL midline_model[%0d]: got %h, required %h", i, gotq[i], expq[i]);
      end
    end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_reset_midword();
    mode = 3'd3;
    rdy_mode = 2;
    for (int i = 0; i < 11; i++) send_px(24'($urandom), 1'b0, 1'b0);
    n_checks++;
    if (v1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre_valid: got tvalid=%b before reset, required 1", v1);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (v1 !== 1'b0 || v0 !== 1'b0 || d1 !== 32'h0 || l1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop: got v=%b/%b d1=%h l=%b, required 0/0/00000000/0", v1, v0, d1, l1);
    end
    gotq.delete(); expq.delete();
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    n_checks++;
    if (s_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready: got tready=%b after reset, required 1", s_ready1);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_px(24'($urandom), 1'b0, 1'b0);
    drain();
    n_checks++;
    if (gotq.size() !== 1) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d words, required 1", gotq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      n_checks++;
      if (gotq[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL rstmid_model[%0d]: got %h, required %h", i, gotq[i], expq[i]);
      end
    end
    gotq.delete(); expq.delete();
    send_px(24'h0, 1'b1, 1'b0);
    drain();
    gotq.delete(); expq.delete();
  endtask

  task automatic test_random();
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      mode = 3'($urandom % 8);
      send_px(24'($urandom), 1'(($urandom % 10 == 0) || i == 399), 1'($urandom % 16 == 0));
      if ($urandom % 5 == 0) begin @(posedge clk); #1; end
    end
    rdy_mode = 0;
    drain();
    n_checks++;
    if (gotq.size() !== expq.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d words, required %0d", gotq.size(), expq.size());
    end
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      n_checks++;
      if (gotq[i] !== expq[i]) begin
        n_fail++;
        $display("FAIL random_model[%0d]: got %h, required %h", i, gotq[i], expq[i]);
      end
    end
    gotq.delete(); expq.delete();
  endtask

  initial begin
    test_reset();
    test_bw();
    test_clr16();
    test_gray4_flush();
    test_backpressure();
    test_midline_mode();
    test_reset_midword();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
